// File: rtl/q8_8_pkg.sv
// q8_8_pkg: shared Q8.8 sign-magnitude constants and types for the add/sub result path.
`default_nettype none

package q8_8_pkg;

  localparam int unsigned Q8_8_MAG_W   = 16;
  localparam int unsigned Q8_8_FRAC_W  = 8;
  localparam logic [Q8_8_MAG_W-1:0] Q8_8_MAG_MAX = 16'hFFFF;

  // Saturated stage output: sign + Q8.8 magnitude.
  typedef struct packed {
    logic                  sign;
    logic [Q8_8_MAG_W-1:0] mag;
  } q8_8_sm_t;

  // Raw add/sub result: sign + Q9.8 magnitude (one extra integer bit).
  typedef struct packed {
    logic                  sign;
    logic [Q8_8_MAG_W:0]   mag;
  } q9_8_sm_t;

endpackage

`default_nettype wire

// File: rtl/q8_8_skid_buf.sv
// q8_8_skid_buf: generic 2-entry valid/ready skid buffer (output register + one skid register).
`default_nettype none

module q8_8_skid_buf #(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_full;
  logic [W-1:0] r_skid_data;
  logic         w_accept;
  logic         w_out_free;

  // in_ready is a flop output, so upstream never sees a combinational path from out_ready.
  assign in_ready   = !r_skid_full;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign w_accept   = in_valid && !r_skid_full;
  assign w_out_free = !r_out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_skid_full <= 1'b0;
      r_skid_data <= '0;
    end else if (w_out_free) begin
      if (r_skid_full) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_skid_data;
        r_skid_full <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_full <= 1'b1;
      r_skid_data <= in_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/q8_8_result_sat_stage.sv
// q8_8_result_sat_stage: saturates a Q9.8 sign-magnitude add/sub result to Q8.8 behind a skid buffer.
// Optional Q8_8_SAT_STATS_EN adds a saturating sat_count output.
`default_nettype none

module q8_8_result_sat_stage
  import q8_8_pkg::*;
#(
  parameter int unsigned MAG_W = Q8_8_MAG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W+1:0] in_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   out_data,
  output logic             out_sat,
  output logic             ovf_sticky,
`ifdef Q8_8_SAT_STATS_EN
  output logic [CNT_W-1:0] sat_count,
`endif
  input  logic             clr_flags
);

  logic             w_ovf;
  logic [MAG_W-1:0] w_mag;
  logic             w_sign;
  logic [MAG_W+1:0] w_din;
  logic [MAG_W+1:0] w_dout;
  logic             w_sat_acc;
  logic             r_ovf_sticky;

  assign w_ovf  = in_result[MAG_W];
  assign w_mag  = w_ovf ? {MAG_W{1'b1}} : in_result[MAG_W-1:0];
  // Drop the sign on a zero magnitude so -0 never leaves the stage.
  assign w_sign = in_result[MAG_W+1] && (w_mag != '0);
  assign w_din  = {w_ovf, w_sign, w_mag};

  q8_8_skid_buf #(
    .W (MAG_W + 2)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_dout)
  );

  assign out_sat    = w_dout[MAG_W+1];
  assign out_data   = w_dout[MAG_W:0];
  assign w_sat_acc  = in_valid && in_ready && w_ovf;
  assign ovf_sticky = r_ovf_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_sat_acc) begin
      r_ovf_sticky <= 1'b1;
    end else if (clr_flags) begin
      r_ovf_sticky <= 1'b0;
    end
  end

`ifdef Q8_8_SAT_STATS_EN
  logic [CNT_W-1:0] r_sat_count;

  assign sat_count = r_sat_count;

  // A clear colliding with a saturated accept counts that accept, leaving 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (w_sat_acc) begin
      if (clr_flags) begin
        r_sat_count <= CNT_W'(1);
      end else if (r_sat_count != {CNT_W{1'b1}}) begin
        r_sat_count <= r_sat_count + CNT_W'(1);
      end
    end else if (clr_flags) begin
      r_sat_count <= '0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_q8_8_result_sat_stage.sv
// Scoreboard bench for q8_8_result_sat_stage: directed vectors, expected {sat,data} queued at accept.
`default_nettype none

module tb_q8_8_result_sat_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic        out_sat;
  logic        ovf_sticky;
  logic        clr_flags;
`ifdef Q8_8_SAT_STATS_EN
  logic [1:0]  sat_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  q8_8_result_sat_stage #(
    .MAG_W (16),
`ifdef Q8_8_SAT_STATS_EN
    .CNT_W (2)
`else
    .CNT_W (16)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .ovf_sticky (ovf_sticky),
`ifdef Q8_8_SAT_STATS_EN
    .sat_count  (sat_count),
`endif
    .clr_flags  (clr_flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got %0h expected none", {out_sat, out_data});
      end else begin
        check("out_sample", 32'({out_sat, out_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Caller sits just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [17:0] res, input logic [17:0] exp);
    bit got = 0;
    in_valid  = 1'b1;
    in_result = res;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (got) exp_q.push_back(exp);
    else check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; out_ready = 1'b1; clr_flags = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_sat",   32'(out_sat),   32'd0);
    check("rst_ovf",       32'(ovf_sticky), 32'd0);
`ifdef Q8_8_SAT_STATS_EN
    check("rst_cnt",       32'(sat_count), 32'd0);
`endif
    tick(); rst = 1'b0; tick();

    // Plain sums, -0 canonicalisation, range edges.
    send(18'h00488, 18'h00488);
    check("lat1_valid", 32'(out_valid), 32'd1);
    check("ovf_clear_nosat", 32'(ovf_sticky), 32'd0);
    send(18'h20000, 18'h00000);
    send(18'h20180, 18'h10180);
    send(18'h0FFFF, 18'h0FFFF);
    send(18'h1FFFF, {1'b1, 17'h0FFFF});
    send(18'h3FFFF, {1'b1, 17'h1FFFF});
    send(18'h30000, {1'b1, 17'h1FFFF});

    // Saturation flag and sticky clear.
    send(18'h12000, {1'b1, 17'h0FFFF});
    check("ovf_set", 32'(ovf_sticky), 32'd1);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    check("ovf_cleared", 32'(ovf_sticky), 32'd0);
    clr_flags = 1'b1;
    send(18'h10000, {1'b1, 17'h0FFFF});
    clr_flags = 1'b0;
    check("ovf_set_wins", 32'(ovf_sticky), 32'd1);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    check("ovf_cleared2", 32'(ovf_sticky), 32'd0);
    tick(); tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: A to output, B to skid, C must wait.
    out_ready = 1'b0;
    send(18'h00100, 18'h00100);
    send(18'h00200, 18'h00200);
    in_valid = 1'b1; in_result = 18'h00300;
    @(negedge clk);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_hold", 32'({out_sat, out_data}), 32'h00100);
    tick(); tick();
    check("stall_in_ready2", 32'(in_ready), 32'd0);
    check("stall_hold2", 32'({out_sat, out_data}), 32'h00100);
    out_ready = 1'b1;
    send(18'h00300, 18'h00300);
    tick(); tick();
    check("fifo_empty", 32'(exp_q.size()), 32'd0);
    check("fifo_idle", 32'(out_valid), 32'd0);

    // Reset with both entries full.
    out_ready = 1'b0;
    send(18'h32000, {1'b1, 17'h0FFFF});
    send(18'h00500, 18'h00500);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_ovf",   32'(ovf_sticky), 32'd0);
    exp_q.delete();
    tick(); rst = 1'b0; out_ready = 1'b1; tick();
    send(18'h00600, 18'h00600);
    check("post_rst_lat1", 32'(out_valid), 32'd1);
    tick(); tick();
    check("post_rst_empty", 32'(exp_q.size()), 32'd0);

`ifdef Q8_8_SAT_STATS_EN
    for (int i = 0; i < 5; i++) send(18'h1ABCD, {1'b1, 17'h0FFFF});
    check("cnt_sat_hold", 32'(sat_count), 32'd3);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    check("cnt_clr", 32'(sat_count), 32'd0);
    send(18'h10001, {1'b1, 17'h0FFFF});
    send(18'h10001, {1'b1, 17'h0FFFF});
    clr_flags = 1'b1;
    send(18'h30001, {1'b1, 17'h1FFFF});
    clr_flags = 1'b0;
    check("cnt_inc_wins", 32'(sat_count), 32'd1);
    tick(); tick();
`endif

    check("final_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
